// File: rtl/btn_cond_pkg.sv
// Purpose : shared types and board defaults for the key-conditioning path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//   Contents: state_t FSM encoding, 50 MHz timing defaults, cnt_width helper.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  // Timing defaults for the 50 MHz board clock.
  localparam int unsigned DEBOUNCE_10MS = 32'd500_000;
  localparam int unsigned REPEAT_1S     = 32'd50_000_000;
  localparam int unsigned REPEAT_250MS  = 32'd12_500_000;

  // Bits needed to hold 0..max_val. Never returns 0, so a disabled
  // feature still yields a legal vector width.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 0) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose : two-flop synchroniser for an asynchronous single-bit input.
// Latency : 2 clk_i edges from d_i sampling to q_o.
// Backpressure: none; samples every cycle.
//   Ports: clk_i clock, rst_ni sync active-low reset (loads RST_VAL into
//          both flops), d_i async input, q_o synchronised output.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Purpose : raw bouncing key -> debounced level plus press/release/repeat/step pulses.
// Latency : press accepted DEBOUNCE_CYCLES+1 edges after the pin edge is first sampled.
// Backpressure: none; pulses are single-cycle events with no handshake.
//   Ports: clk clock, reset sync active-low reset, btn_raw async key pin,
//          btn_level debounced pressed level, press_pulse / release_pulse /
//          repeat_pulse one-cycle events, step_pulse = press | repeat.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_1S,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_250MS,
  parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int unsigned DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = cnt_width(HMAX);

  // deb_cnt holds the number of samples already seen at the new level, so
  // the sample arriving while deb_cnt == DEBOUNCE_CYCLES-1 is the accepting one.
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE    = DW'(1);
  localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_PERIOD);
  localparam bit            REPEAT_EN  = (REPEAT_DELAY != 0);

  logic btn_sync;
  logic active;

  state_t          state_q;
  logic [DW-1:0]   deb_cnt_q;
  logic [DW-1:0]   deb_cnt_d;
  logic [HW-1:0]   hold_cnt_q;
  logic [HW-1:0]   hold_cnt_d;
  logic [HW-1:0]   hold_target;
  logic            rep_armed_q;
  logic            hold_hit;
  logic            level_q;
  logic            press_q;
  logic            release_q;
  logic            repeat_q;
  logic            step_q;

  // Reset loads the inactive pin level so a held key after reset is seen
  // as a fresh press rather than a phantom one during reset.
  sync_2ff #(
    .RST_VAL(ACTIVE_LOW_IN)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (btn_raw),
    .q_o   (btn_sync)
  );

  assign active = btn_sync ^ ACTIVE_LOW_IN;

  // Repeat uses one counter in two phases: up to REPEAT_DELAY for the first
  // pulse, then restarting from zero and counting to REPEAT_PERIOD. Neither
  // phase can exceed HMAX, so the counter never wraps.
  assign deb_cnt_d   = deb_cnt_q + DEB_ONE;
  assign hold_cnt_d  = hold_cnt_q + HW'(1);
  assign hold_target = rep_armed_q ? HOLD_NEXT : HOLD_FIRST;
  assign hold_hit    = (hold_cnt_d == hold_target);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_armed_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (active) begin
            state_q   <= DEB_PRESS;
            deb_cnt_q <= DEB_ONE;
          end
        end
        DEB_PRESS: begin
          if (!active) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q >= DEB_LAST) begin
            state_q     <= PRESSED;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            rep_armed_q <= 1'b0;
            level_q     <= 1'b1;
            press_q     <= 1'b1;
            step_q      <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_d;
          end
        end
        PRESSED: begin
          if (!active) begin
            state_q   <= DEB_RELEASE;
            deb_cnt_q <= DEB_ONE;
          end else if (REPEAT_EN) begin
            if (hold_hit) begin
              hold_cnt_q  <= '0;
              rep_armed_q <= 1'b1;
              repeat_q    <= 1'b1;
              step_q      <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_d;
            end
          end
        end
        DEB_RELEASE: begin
          // hold_cnt is left untouched here so a bounce resumes the repeat phase.
          if (active) begin
            state_q   <= PRESSED;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q >= DEB_LAST) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          deb_cnt_q <= '0;
        end
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose : self-checking bench for button_conditioner (DEB=4, DELAY=10, PERIOD=3).
// Latency : one expected vector per clock edge, compared 1 ns after the edge.
// Backpressure: n/a.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b1;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic step_pulse;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [4:0] val;
    logic [4:0] mask;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [4:0] ALL   = 5'b11111;
  // Repeat/step unchecked: used only where the repeat phase after a
  // release bounce is not pinned down to a single edge.
  localparam logic [4:0] NOREP = 5'b11100;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .ACTIVE_LOW_IN  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .step_pulse   (step_pulse)
  );

  task automatic check_eq(input string tag, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {lvl,prs,rel,rep,stp}=%b want=%b", tag, act, exp);
    end
  endtask

  // Output vector {level, press, release, repeat, step}; step is press|repeat.
  function automatic logic [4:0] ev(input logic lvl, input logic prs,
                                    input logic rel, input logic rep);
    return {lvl, prs, rel, rep, prs | rep};
  endfunction

  // Drive one edge's inputs, queue what the outputs must be after that edge,
  // then pop and compare once the DUT has produced them.
  task automatic tick(input logic rst_v, input logic raw_v, input logic [4:0] e_val,
                      input logic [4:0] e_mask, input string tag);
    exp_t e;
    @(negedge clk);
    reset   = rst_v;
    btn_raw = raw_v;
    sb_q.push_back('{val: e_val, mask: e_mask});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 5'b00000, 5'b11111);
    end else begin
      e = sb_q.pop_front();
      check_eq(tag, {btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse} & e.mask,
               e.val & e.mask);
    end
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 5'b00000, ALL, $sformatf("%s_rst%0d", tag, i));
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 5'b00000, ALL, $sformatf("%s_idle%0d", tag, i));
  endtask

  initial begin
    logic raw;

    // 1. Reset held with key pressed, then released with key still down.
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 5'b00000, ALL, $sformatf("s1_rst%0d", k));
    for (int k = 0; k < 8; k++)
      tick(1'b1, 1'b0, ev(k >= 5, k == 5, 1'b0, 1'b0), ALL, $sformatf("s1_k%0d", k));

    // 2+5. Clean hold with repeats, release bounce, then real release at r=35.
    do_reset("s2");
    for (int k = 0; k < 25; k++)
      tick(1'b1, 1'b0,
           ev(k >= 5, k == 5, 1'b0, (k == 15) || (k == 18) || (k == 21) || (k == 24)),
           ALL, $sformatf("s2_k%0d", k));
    for (int k = 25; k < 44; k++) begin
      raw = (k == 25) || (k == 26) || (k >= 35);
      if (k >= 29 && k <= 36)
        tick(1'b1, raw, ev(1'b1, 1'b0, 1'b0, 1'b0), NOREP, $sformatf("s5_k%0d", k));
      else
        tick(1'b1, raw, ev(k < 40, 1'b0, k == 40, 1'b0), ALL, $sformatf("s5_k%0d", k));
    end

    // 3. Press bounce: low, low, high, then low; release at edge 11.
    do_reset("s3");
    for (int k = 0; k < 20; k++) begin
      raw = (k == 2) || (k >= 11);
      tick(1'b1, raw, ev((k >= 8) && (k < 16), k == 8, k == 16, 1'b0), ALL,
           $sformatf("s3_k%0d", k));
    end

    // 4. Glitch shorter than the debounce window.
    do_reset("s4");
    for (int k = 0; k < 12; k++)
      tick(1'b1, (k >= 3), 5'b00000, ALL, $sformatf("s4_k%0d", k));

    // 6. Reset while PRESSED, key still down across reset.
    do_reset("s6");
    for (int k = 0; k < 12; k++)
      tick(1'b1, 1'b0, ev(k >= 5, k == 5, 1'b0, 1'b0), ALL, $sformatf("s6_pre%0d", k));
    for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 5'b00000, ALL, $sformatf("s6_rst%0d", k));
    for (int k = 0; k < 20; k++)
      tick(1'b1, 1'b0, ev(k >= 5, k == 5, 1'b0, (k == 15) || (k == 18)), ALL,
           $sformatf("s6_k%0d", k));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
